// File: rtl/nios_mul_cell_sequencer.sv
// rtl/nios_mul_cell_sequencer.sv - two-requester sequencer for the 16x16 three-partial-product multiplier cell
module nios_mul_cell_sequencer #(
   parameter int CELL_LATENCY = 1
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_req0_valid,
   output logic        o_req0_ready,
   input  logic [31:0] i_req0_a,
   input  logic [31:0] i_req0_b,
   input  logic        i_req0_hi,
   input  logic        i_req1_valid,
   output logic        o_req1_ready,
   input  logic [31:0] i_req1_a,
   input  logic [31:0] i_req1_b,
   input  logic        i_req1_hi,
   output logic [31:0] o_cell_src1,
   output logic [31:0] o_cell_src2,
   output logic        o_cell_en,
   input  logic [31:0] i_cell_p1,
   input  logic [31:0] i_cell_p2,
   input  logic [31:0] i_cell_p3,
   output logic        o_rsp_valid,
   input  logic        i_rsp_ready,
   output logic        o_rsp_id,
   output logic [31:0] o_rsp_data
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_MUL1 = 3'd1,
      S_CAP1 = 3'd2,
      S_MUL2 = 3'd3,
      S_CAP2 = 3'd4,
      S_RESP = 3'd5
   } state_t;

   // Last count value of an enabled cell pass (cell register depth minus one).
   localparam logic [2:0] CNT_LAST = 3'(CELL_LATENCY - 1);

   state_t      r_state;
   state_t      w_next_state;
   logic [2:0]  r_cnt;
   logic [31:0] r_a;
   logic [31:0] r_b;
   logic        r_hi;
   logic        r_id;
   logic        r_last_grant;
   logic [31:0] r_pp_ll;
   logic [31:0] r_pp_lh;
   logic [31:0] r_pp_hl;
   logic [31:0] r_res;

   logic        w_grant0;
   logic        w_grant1;
   logic        w_accept;
   logic        w_cnt_done;
   logic [31:0] w_lo;
   logic [32:0] w_mid;
   logic [31:0] w_low_sum;
   logic        w_low_carry;
   logic [31:0] w_hi;

   // Round-robin grant: a lone requester wins, on a tie the one not granted last time wins.
   assign w_grant0 = i_req0_valid & (~i_req1_valid | r_last_grant);
   assign w_grant1 = i_req1_valid & (~i_req0_valid | ~r_last_grant);
   assign w_accept = (r_state == S_IDLE) & (w_grant0 | w_grant1);

   assign w_cnt_done = (r_cnt == CNT_LAST);

   // Low word straight from the cell outputs; the high cross terms fall off the top mod 2^32.
   assign w_lo = i_cell_p1 + (i_cell_p2 << 16) + (i_cell_p3 << 16);

   // High word: pp_hh + mid[32:16] + carry out of (mid[15:0] << 16) + pp_ll.
   assign w_mid       = {1'b0, r_pp_lh} + {1'b0, r_pp_hl};
   assign w_low_sum   = {w_mid[15:0], 16'h0000} + r_pp_ll;
   assign w_low_carry = (w_low_sum < r_pp_ll);
   assign w_hi        = i_cell_p1 + {15'h0000, w_mid[32:16]} + {31'h0, w_low_carry};

   assign o_rsp_id   = r_id;
   assign o_rsp_data = r_res;

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: if (w_accept) w_next_state = S_MUL1;
         S_MUL1: if (w_cnt_done) w_next_state = S_CAP1;
         S_CAP1: w_next_state = r_hi ? S_MUL2 : S_RESP;
         S_MUL2: if (w_cnt_done) w_next_state = S_CAP2;
         S_CAP2: w_next_state = S_RESP;
         S_RESP: if (i_rsp_ready) w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // Outputs decoded from state; cell operands are zero whenever the cell is not being driven.
   always_comb begin
      o_req0_ready = 1'b0;
      o_req1_ready = 1'b0;
      o_cell_en    = 1'b0;
      o_cell_src1  = 32'h0;
      o_cell_src2  = 32'h0;
      o_rsp_valid  = 1'b0;
      case (r_state)
         S_IDLE: begin
            o_req0_ready = w_grant0;
            o_req1_ready = w_grant1;
         end
         S_MUL1: begin
            o_cell_en   = 1'b1;
            o_cell_src1 = r_a;
            o_cell_src2 = r_b;
         end
         S_MUL2: begin
            o_cell_en   = 1'b1;
            o_cell_src1 = {16'h0000, r_a[31:16]};
            o_cell_src2 = {16'h0000, r_b[31:16]};
         end
         S_RESP: o_rsp_valid = 1'b1;
         default: ;
      endcase
   end

   // Counts enabled cycles of the current cell pass.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_cnt <= 3'd0;
      end else if ((r_state == S_MUL1) || (r_state == S_MUL2)) begin
         r_cnt <= w_cnt_done ? 3'd0 : r_cnt + 3'd1;
      end else begin
         r_cnt <= 3'd0;
      end
   end

   // Operand latch on accept, partial-product capture and result assembly.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_a          <= 32'h0;
         r_b          <= 32'h0;
         r_hi         <= 1'b0;
         r_id         <= 1'b0;
         r_last_grant <= 1'b1;
         r_pp_ll      <= 32'h0;
         r_pp_lh      <= 32'h0;
         r_pp_hl      <= 32'h0;
         r_res        <= 32'h0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_a          <= w_grant0 ? i_req0_a : i_req1_a;
                  r_b          <= w_grant0 ? i_req0_b : i_req1_b;
                  r_hi         <= w_grant0 ? i_req0_hi : i_req1_hi;
                  r_id         <= w_grant1;
                  r_last_grant <= w_grant1;
               end
            end
            S_CAP1: begin
               r_pp_ll <= i_cell_p1;
               r_pp_lh <= i_cell_p2;
               r_pp_hl <= i_cell_p3;
               if (!r_hi) r_res <= w_lo;
            end
            S_CAP2: r_res <= w_hi;
            default: ;
         endcase
      end
   end

endmodule
